// File: rtl/husky_frame_tx_if.sv
// Request and byte-stream signals between the command-set stage, the HuskyLens
// framer and the UART TX byte engine. The framer uses the slave modport.
interface husky_frame_tx_if;
    logic       req_husky_start;
    logic [7:0] req_husky_cmd;
    logic [7:0] req_husky_data_len;
    logic [7:0] req_data_idx;
    logic [7:0] req_data_byte;
    logic       req_husky_done;
    logic       req_husky_err;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    modport master (
        output req_husky_start, req_husky_cmd, req_husky_data_len, req_data_byte, tx_ready,
        input  req_data_idx, req_husky_done, req_husky_err, tx_data, tx_valid, busy
    );

    modport slave (
        input  req_husky_start, req_husky_cmd, req_husky_data_len, req_data_byte, tx_ready,
        output req_data_idx, req_husky_done, req_husky_err, tx_data, tx_valid, busy
    );
endinterface

// File: rtl/husky_frame_tx.sv
// HuskyLens request framer: emits 55 AA ADDR len cmd [data] chksum over valid/ready.
// Optional stall timeout is built when HUSKY_TX_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for req_husky_start
// SEND  | streaming frame byte k; tx_valid held high
// DONE  | one cycle; done (and err if rejected/timed out) pulses
// GAP   | GAP_CYCLES cycles with start ignored
module husky_frame_tx #(
    parameter logic [7:0]  HUSKY_ADDR     = 8'h11,
    parameter int unsigned MAX_DATA_LEN   = 16,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic             clk,
    input logic             rst_n,
    husky_frame_tx_if.slave bus
);
    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]  MAX_LEN8 = 8'(MAX_DATA_LEN);

    // Frame index k must fit in 8 bits and the counter needs a nonzero limit.
    if (MAX_DATA_LEN > 249) begin : g_bad_max_len
        $error("MAX_DATA_LEN too large for an 8-bit frame index");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE, ST_GAP} state_t;

    state_t           state_q, state_d;
    logic [7:0]       k_q, k_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [GAP_W-1:0] gap_q, gap_d;

`ifdef HUSKY_TX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    logic       accept;
    logic [7:0] k_next;
    logic [7:0] last_k;
    logic [7:0] csum_next;
    logic [7:0] next_byte;

    always_comb begin
        accept    = tx_valid_q & bus.tx_ready;
        k_next    = k_q + 8'd1;
        last_k    = len_q + 8'd5;
        csum_next = csum_q + tx_data_q;

        // Byte that follows the one currently on tx_data.
        if (k_next == 8'd1)       next_byte = 8'hAA;
        else if (k_next == 8'd2)  next_byte = HUSKY_ADDR;
        else if (k_next == 8'd3)  next_byte = len_q;
        else if (k_next == 8'd4)  next_byte = cmd_q;
        else if (k_next == last_k) next_byte = csum_next;
        else                      next_byte = bus.req_data_byte;
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        len_d      = len_q;
        cmd_d      = cmd_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        gap_d      = gap_q;
`ifdef HUSKY_TX_TIMEOUT_EN
        to_cnt_d   = '0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_husky_start) begin
                    len_d  = bus.req_husky_data_len;
                    cmd_d  = bus.req_husky_cmd;
                    csum_d = 8'h00;
                    k_d    = 8'd0;
                    if (bus.req_husky_data_len > MAX_LEN8) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = ST_SEND;
                        tx_data_d  = 8'h55;
                        tx_valid_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (accept) begin
                    csum_d = csum_next;
                    if (k_q == last_k) begin
                        tx_valid_d = 1'b0;
                        k_d        = 8'd0;
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                    end else begin
                        k_d       = k_next;
                        tx_data_d = next_byte;
                    end
                end
`ifdef HUSKY_TX_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    tx_valid_d = 1'b0;
                    k_d        = 8'd0;
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (GAP_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            len_q      <= '0;
            cmd_q      <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            gap_q      <= '0;
`ifdef HUSKY_TX_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            len_q      <= len_d;
            cmd_q      <= cmd_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            gap_q      <= gap_d;
`ifdef HUSKY_TX_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    // Look one byte ahead so the payload byte is ready when byte k is accepted.
    assign bus.req_data_idx   = (state_q == ST_SEND && k_q >= 8'd4 && k_q <= len_q + 8'd3)
                                ? k_q - 8'd4 : 8'd0;
    assign bus.tx_data        = tx_data_q;
    assign bus.tx_valid       = tx_valid_q;
    assign bus.req_husky_done = done_q;
    assign bus.req_husky_err  = err_q;
    assign bus.busy           = (state_q != ST_IDLE);
endmodule
